riscv_trap_ctrl: RTL and testbench
==================================

Name: riscv_trap_ctrl

Overview:
Core-side responder to the interrupt controller's request/acknowledge interface. It consumes the controller's interrupt request and cause code, and waits for an instruction boundary. At the boundary it performs machine-mode trap entry: it saves mepc, updates mcause and mstatus, redirects fetch to mtvec, and acknowledges the controller. It also handles mret and owns the trap CSRs (mstatus, mtvec, mepc, mcause). It drives the global MIE bit back to the controller.

Parameters:
MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE and MODE).
VECTORED_EN, 1'b1, 1 = mtvec MODE 1 (vectored) is writable; 0 = MODE is hardwired to 0.

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
irq_exec_i  in  1  interrupt request from interrupt controller, held until acknowledged
irq_cause_i  in  5  exception code accompanying irq_exec_i
irq_ack_o  out  1  one-cycle acknowledge to interrupt controller
mie_o  out  1  mstatus.MIE, fed to the controller's global enable
boundary_valid_i  in  1  pipeline is at an instruction boundary; boundary_pc_i is the next instruction not yet executed
boundary_pc_i  in  32  PC to resume at after the handler
mret_i  in  1  mret retiring this cycle (single-cycle pulse)
csr_we_i  in  1  CSR write strobe
csr_addr_i  in  12  CSR address for read and write
csr_wdata_i  in  32  CSR write data
csr_rdata_o  out  32  combinational CSR read data for csr_addr_i
redirect_valid_o  out  1  one-cycle fetch redirect / pipeline flush
redirect_pc_o  out  32  redirect target, valid with redirect_valid_o
trap_active_o  out  1  high while in WAIT_BND or ENTER (stalls issue of new CSR/mret)

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, mstatus.MIE=0, MPIE=0, mtvec=MTVEC_RESET (MODE forced 0 if VECTORED_EN=0 or MODE>1), mepc=0, mcause=0. irq_ack_o, redirect_valid_o and trap_active_o are 0; redirect_pc_o=0. Reset mid-trap abandons the sequence: no ack is issued and no CSR is updated.
- CSR map: 0x300 mstatus (bit3 MIE, bit7 MPIE, bits12:11 MPP read 2'b11, others read 0 and ignore writes). 0x305 mtvec (BASE [31:2], MODE [1:0]; MODE writes of 2 or 3 store 0, WARL). 0x341 mepc (bits[1:0] always 0). 0x342 mcause (bit31 interrupt flag, bits[4:0] code, others 0). Unmapped addresses read 0 and ignore writes. Writes take effect at the edge.
- States:
  - IDLE: if mret_i, then MIE<=MPIE, MPIE<=1, redirect_valid_o=1 next cycle with redirect_pc_o=mepc. Otherwise, if irq_exec_i & MIE, go to WAIT_BND.
  - mret has priority over a same-cycle interrupt; the interrupt is re-evaluated in the following cycles using the restored MIE.
  - WAIT_BND: if irq_exec_i drops, return to IDLE with no side effects. If boundary_valid_i is high in cycle N:
    - at the end of cycle N: mepc<={boundary_pc_i[31:2],2'b00}, mcause<={1'b1,26'b0,irq_cause_i}, MPIE<=MIE, MIE<=0; go to ENTER.
    - a CSR write in WAIT_BND is permitted, but hardware trap updates override software writes to the same field in the same cycle.
  - ENTER (cycle N+1, one cycle): irq_ack_o=1 and redirect_valid_o=1.
    - redirect_pc_o = BASE when MODE=0.
    - redirect_pc_o = BASE + 4*irq_cause_i when MODE=1. The sum is 32-bit and wraps modulo 2^32.
    - Next state is IDLE.
- Acknowledge rules:
  - irq_ack_o is never high for more than one cycle per trap.
  - The controller deasserts irq_exec_i after the ack. Because MIE=0 after entry, IDLE cannot re-take the request during the drop.
- CSR write to mstatus.MIE while in IDLE with irq_exec_i high: the new MIE value gates the transition in the following cycle.
- csr_rdata_o reflects register contents, not the same-cycle write.

Test Plan:
- Reset, then read 0x300/0x305/0x341/0x342 -> mstatus=32'h0000_1800, mtvec=MTVEC_RESET, mepc=0, mcause=0; irq_ack_o=0.
- Write mtvec=32'h0000_1000, MIE=1. Assert irq_exec_i with cause 11, then boundary_valid_i with pc 32'h0000_0204 two cycles later -> next cycle: ack=1, redirect_pc_o=32'h1000. Afterwards mepc=32'h204, mcause=32'h8000_000B, MIE=0, MPIE=1.
- mtvec=32'h0000_1001 (vectored), cause 7 -> redirect_pc_o=32'h0000_101C. Write mtvec=32'h0000_1003 -> reads back 32'h0000_1000.
- After trap entry, pulse mret_i -> next cycle redirect_valid_o=1 with redirect_pc_o=mepc; MIE=1, MPIE=1.
- irq_exec_i high with MIE=0 for 10 cycles -> no ack, state stays IDLE. Then set MIE=1 -> WAIT_BND the next cycle. Drop irq_exec_i before any boundary -> return to IDLE, mepc unchanged.
- rst_i asserted in WAIT_BND, and separately in ENTER -> no ack after reset, all registers at reset values. Also mret_i and irq_exec_i in the same IDLE cycle with MPIE=1 -> mret redirect first, trap taken at a later boundary.

Source files
------------

// File: rtl/riscv_trap_ctrl_if.sv
// Core-side trap interface: interrupt handshake, instruction boundary, mret,
// CSR access and fetch redirect. master = pipeline/controller side, slave = trap block.
interface riscv_trap_ctrl_if;
   logic        irq_exec_i;
   logic [4:0]  irq_cause_i;
   logic        irq_ack_o;
   logic        mie_o;
   logic        boundary_valid_i;
   logic [31:0] boundary_pc_i;
   logic        mret_i;
   logic        csr_we_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        trap_active_o;

   modport master (
      output irq_exec_i, irq_cause_i, boundary_valid_i, boundary_pc_i, mret_i,
             csr_we_i, csr_addr_i, csr_wdata_i,
      input  irq_ack_o, mie_o, csr_rdata_o, redirect_valid_o, redirect_pc_o, trap_active_o
   );

   modport slave (
      input  irq_exec_i, irq_cause_i, boundary_valid_i, boundary_pc_i, mret_i,
             csr_we_i, csr_addr_i, csr_wdata_i,
      output irq_ack_o, mie_o, csr_rdata_o, redirect_valid_o, redirect_pc_o, trap_active_o
   );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap entry / mret sequencer owning mstatus, mtvec, mepc and mcause.
// Takes a pending interrupt at the next instruction boundary and acks the controller.
module riscv_trap_ctrl #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter bit          VECTORED_EN = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   riscv_trap_ctrl_if.slave        bus
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic RESET_VEC = VECTORED_EN && (MTVEC_RESET[1:0] == 2'b01);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_BND,
      ENTER
   } state_e;

   state_e      state_q, state_d;
   logic        mie_q, mie_d;
   logic        mpie_q, mpie_d;
   logic [29:0] mtvec_base_q, mtvec_base_d;
   logic        mtvec_vec_q, mtvec_vec_d;
   logic [29:0] mepc_q, mepc_d;
   logic        mcause_irq_q, mcause_irq_d;
   logic [4:0]  mcause_code_q, mcause_code_d;
   logic        ret_valid_q, ret_valid_d;
   logic [31:0] ret_pc_q, ret_pc_d;

   logic [31:0] trap_pc;
   logic        unused_pc_low;

   assign unused_pc_low = ^bus.boundary_pc_i[1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
         mtvec_base_q  <= MTVEC_RESET[31:2];
         mtvec_vec_q   <= RESET_VEC;
         mepc_q        <= '0;
         mcause_irq_q  <= 1'b0;
         mcause_code_q <= '0;
         ret_valid_q   <= 1'b0;
         ret_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
         mtvec_base_q  <= mtvec_base_d;
         mtvec_vec_q   <= mtvec_vec_d;
         mepc_q        <= mepc_d;
         mcause_irq_q  <= mcause_irq_d;
         mcause_code_q <= mcause_code_d;
         ret_valid_q   <= ret_valid_d;
         ret_pc_q      <= ret_pc_d;
      end
   end

   // Software write first; hardware trap/mret updates below override it field by field.
   always_comb begin
      state_d       = state_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;
      mtvec_base_d  = mtvec_base_q;
      mtvec_vec_d   = mtvec_vec_q;
      mepc_d        = mepc_q;
      mcause_irq_d  = mcause_irq_q;
      mcause_code_d = mcause_code_q;
      ret_valid_d   = 1'b0;
      ret_pc_d      = '0;

      if (bus.csr_we_i) begin
         case (bus.csr_addr_i)
            CSR_MSTATUS: begin
               mie_d  = bus.csr_wdata_i[3];
               mpie_d = bus.csr_wdata_i[7];
            end
            CSR_MTVEC: begin
               mtvec_base_d = bus.csr_wdata_i[31:2];
               mtvec_vec_d  = VECTORED_EN && (bus.csr_wdata_i[1:0] == 2'b01);
            end
            CSR_MEPC: mepc_d = bus.csr_wdata_i[31:2];
            CSR_MCAUSE: begin
               mcause_irq_d  = bus.csr_wdata_i[31];
               mcause_code_d = bus.csr_wdata_i[4:0];
            end
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (bus.mret_i) begin
               mie_d       = mpie_q;
               mpie_d      = 1'b1;
               ret_valid_d = 1'b1;
               ret_pc_d    = {mepc_q, 2'b00};
            end else if (bus.irq_exec_i && mie_q) begin
               state_d = WAIT_BND;
            end
         end
         WAIT_BND: begin
            if (!bus.irq_exec_i) begin
               state_d = IDLE;
            end else if (bus.boundary_valid_i) begin
               mepc_d        = bus.boundary_pc_i[31:2];
               mcause_irq_d  = 1'b1;
               mcause_code_d = bus.irq_cause_i;
               mpie_d        = mie_q;
               mie_d         = 1'b0;
               state_d       = ENTER;
            end
         end
         ENTER:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mcause code holds the cause captured at the boundary, i.e. the held irq_cause_i.
   always_comb begin
      trap_pc = {mtvec_base_q, 2'b00};
      if (mtvec_vec_q) begin
         trap_pc = {mtvec_base_q, 2'b00} + {25'b0, mcause_code_q, 2'b00};
      end
   end

   always_comb begin
      bus.irq_ack_o        = (state_q == ENTER);
      bus.redirect_valid_o = (state_q == ENTER) || ret_valid_q;
      bus.redirect_pc_o    = (state_q == ENTER) ? trap_pc : ret_pc_q;
      bus.trap_active_o    = (state_q != IDLE);
      bus.mie_o            = mie_q;
   end

   always_comb begin
      bus.csr_rdata_o = '0;
      case (bus.csr_addr_i)
         CSR_MSTATUS: begin
            bus.csr_rdata_o[12:11] = 2'b11;
            bus.csr_rdata_o[7]     = mpie_q;
            bus.csr_rdata_o[3]     = mie_q;
         end
         CSR_MTVEC:  bus.csr_rdata_o = {mtvec_base_q, 1'b0, mtvec_vec_q};
         CSR_MEPC:   bus.csr_rdata_o = {mepc_q, 2'b00};
         CSR_MCAUSE: bus.csr_rdata_o = {mcause_irq_q, 26'b0, mcause_code_q};
         default:    bus.csr_rdata_o = '0;
      endcase
   end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Self-checking bench for riscv_trap_ctrl: directed scenarios with fixed expectations,
// then randomized traffic against a cycle-level behavioural model of the trap rules.
module tb_riscv_trap_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   riscv_trap_ctrl_if bus ();

   riscv_trap_ctrl #(
      .MTVEC_RESET(32'h0000_0000),
      .VECTORED_EN(1'b1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.irq_exec_i       = 1'b0;
      bus.irq_cause_i      = '0;
      bus.boundary_valid_i = 1'b0;
      bus.boundary_pc_i    = '0;
      bus.mret_i           = 1'b0;
      bus.csr_we_i         = 1'b0;
      bus.csr_addr_i       = '0;
      bus.csr_wdata_i      = '0;
   endtask

   task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
      bus.csr_we_i    = 1'b1;
      bus.csr_addr_i  = a;
      bus.csr_wdata_i = d;
      tick();
      bus.csr_we_i    = 1'b0;
   endtask

   task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
      bus.csr_addr_i = a;
      #1;
      d = bus.csr_rdata_o;
   endtask

   task automatic test_reset();
      logic [31:0] r;
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (bus.irq_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0h exp=0", bus.irq_ack_o); end
      checks++; if (bus.redirect_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rv got=%0h exp=0", bus.redirect_valid_o); end
      checks++; if (bus.redirect_pc_o !== 32'h0) begin failures++; $display("FAIL reset_rpc got=%08h exp=0", bus.redirect_pc_o); end
      checks++; if (bus.trap_active_o !== 1'b0) begin failures++; $display("FAIL reset_ta got=%0h exp=0", bus.trap_active_o); end
      checks++; if (bus.mie_o !== 1'b0) begin failures++; $display("FAIL reset_mie got=%0h exp=0", bus.mie_o); end
      csr_rd(12'h300, r);
      checks++; if (r !== 32'h0000_1800) begin failures++; $display("FAIL reset_mstatus got=%08h exp=00001800", r); end
      csr_rd(12'h305, r);
      checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL reset_mtvec got=%08h exp=00000000", r); end
      csr_rd(12'h341, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_mepc got=%08h exp=0", r); end
      csr_rd(12'h342, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_mcause got=%08h exp=0", r); end
   endtask

   task automatic test_trap_entry();
      logic [31:0] r;
      csr_wr(12'h305, 32'h0000_1000);
      csr_wr(12'h300, 32'h0000_0008);
      bus.irq_exec_i  = 1'b1;
      bus.irq_cause_i = 5'd11;
      tick();
      checks++; if (bus.trap_active_o !== 1'b1) begin failures++; $display("FAIL entry_wait got=%0h exp=1", bus.trap_active_o); end
      tick();
      bus.boundary_valid_i = 1'b1;
      bus.boundary_pc_i    = 32'h0000_0204;
      tick();
      bus.boundary_valid_i = 1'b0;
      checks++; if (bus.irq_ack_o !== 1'b1) begin failures++; $display("FAIL entry_ack got=%0h exp=1", bus.irq_ack_o); end
      checks++; if (bus.redirect_valid_o !== 1'b1) begin failures++; $display("FAIL entry_rv got=%0h exp=1", bus.redirect_valid_o); end
      checks++; if (bus.redirect_pc_o !== 32'h0000_1000) begin failures++; $display("FAIL entry_rpc got=%08h exp=00001000", bus.redirect_pc_o); end
      tick();
      checks++; if (bus.irq_ack_o !== 1'b0) begin failures++; $display("FAIL entry_ack_once got=%0h exp=0", bus.irq_ack_o); end
      checks++; if (bus.trap_active_o !== 1'b0) begin failures++; $display("FAIL entry_no_retake got=%0h exp=0", bus.trap_active_o); end
      bus.irq_exec_i = 1'b0;
      tick();
      csr_rd(12'h341, r);
      checks++; if (r !== 32'h0000_0204) begin failures++; $display("FAIL entry_mepc got=%08h exp=00000204", r); end
      csr_rd(12'h342, r);
      checks++; if (r !== 32'h8000_000B) begin failures++; $display("FAIL entry_mcause got=%08h exp=8000000b", r); end
      csr_rd(12'h300, r);
      checks++; if (r !== 32'h0000_1880) begin failures++; $display("FAIL entry_mstatus got=%08h exp=00001880", r); end
   endtask

   task automatic test_mret();
      logic [31:0] r;
      bus.mret_i = 1'b1;
      tick();
      bus.mret_i = 1'b0;
      checks++; if (bus.redirect_valid_o !== 1'b1) begin failures++; $display("FAIL mret_rv got=%0h exp=1", bus.redirect_valid_o); end
      checks++; if (bus.redirect_pc_o !== 32'h0000_0204) begin failures++; $display("FAIL mret_rpc got=%08h exp=00000204", bus.redirect_pc_o); end
      checks++; if (bus.irq_ack_o !== 1'b0) begin failures++; $display("FAIL mret_ack got=%0h exp=0", bus.irq_ack_o); end
      csr_rd(12'h300, r);
      checks++; if (r !== 32'h0000_1888) begin failures++; $display("FAIL mret_mstatus got=%08h exp=00001888", r); end
      tick();
      checks++; if (bus.redirect_valid_o !== 1'b0) begin failures++; $display("FAIL mret_rv_once got=%0h exp=0", bus.redirect_valid_o); end
   endtask

   task automatic test_vectored();
      logic [31:0] r;
      csr_wr(12'h305, 32'h0000_1001);
      csr_rd(12'h305, r);
      checks++; if (r !== 32'h0000_1001) begin failures++; $display("FAIL vec_mtvec got=%08h exp=00001001", r); end
      bus.irq_exec_i  = 1'b1;
      bus.irq_cause_i = 5'd7;
      tick();
      bus.boundary_valid_i = 1'b1;
      bus.boundary_pc_i    = 32'h0000_0300;
      tick();
      bus.boundary_valid_i = 1'b0;
      checks++; if (bus.irq_ack_o !== 1'b1) begin failures++; $display("FAIL vec_ack got=%0h exp=1", bus.irq_ack_o); end
      checks++; if (bus.redirect_pc_o !== 32'h0000_101C) begin failures++; $display("FAIL vec_rpc got=%08h exp=0000101c", bus.redirect_pc_o); end
      bus.irq_exec_i = 1'b0;
      tick();
      csr_wr(12'h305, 32'h0000_1003);
      csr_rd(12'h305, r);
      checks++; if (r !== 32'h0000_1000) begin failures++; $display("FAIL vec_warl got=%08h exp=00001000", r); end
   endtask

   task automatic test_mie_gate();
      logic [31:0] r;
      csr_wr(12'h300, 32'h0000_0000);
      bus.irq_exec_i  = 1'b1;
      bus.irq_cause_i = 5'd2;
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++; if (bus.irq_ack_o !== 1'b0 || bus.trap_active_o !== 1'b0) begin
            failures++; $display("FAIL gate_idle cyc=%0d ack=%0h ta=%0h exp=0/0", i, bus.irq_ack_o, bus.trap_active_o);
         end
      end
      csr_wr(12'h300, 32'h0000_0008);
      checks++; if (bus.trap_active_o !== 1'b0) begin failures++; $display("FAIL gate_write_cycle got=%0h exp=0", bus.trap_active_o); end
      tick();
      checks++; if (bus.trap_active_o !== 1'b1) begin failures++; $display("FAIL gate_wait got=%0h exp=1", bus.trap_active_o); end
      bus.irq_exec_i = 1'b0;
      tick();
      checks++; if (bus.trap_active_o !== 1'b0) begin failures++; $display("FAIL gate_drop got=%0h exp=0", bus.trap_active_o); end
      tick();
      checks++; if (bus.irq_ack_o !== 1'b0) begin failures++; $display("FAIL gate_drop_ack got=%0h exp=0", bus.irq_ack_o); end
      csr_rd(12'h341, r);
      checks++; if (r !== 32'h0000_0300) begin failures++; $display("FAIL gate_mepc got=%08h exp=00000300", r); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      bus.irq_exec_i  = 1'b1;
      bus.irq_cause_i = 5'd5;
      tick();
      checks++; if (bus.trap_active_o !== 1'b1) begin failures++; $display("FAIL rstw_wait got=%0h exp=1", bus.trap_active_o); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.trap_active_o !== 1'b0 || bus.irq_ack_o !== 1'b0) begin
         failures++; $display("FAIL rstw_state ta=%0h ack=%0h exp=0/0", bus.trap_active_o, bus.irq_ack_o);
      end
      csr_rd(12'h300, r);
      checks++; if (r !== 32'h0000_1800) begin failures++; $display("FAIL rstw_mstatus got=%08h exp=00001800", r); end
      csr_rd(12'h305, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL rstw_mtvec got=%08h exp=0", r); end
      csr_rd(12'h341, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL rstw_mepc got=%08h exp=0", r); end
      csr_wr(12'h300, 32'h0000_0008);
      tick();
      bus.boundary_valid_i = 1'b1;
      bus.boundary_pc_i    = 32'h0000_0444;
      tick();
      checks++; if (bus.irq_ack_o !== 1'b1) begin failures++; $display("FAIL rste_enter got=%0h exp=1", bus.irq_ack_o); end
      rst = 1'b1;
      bus.boundary_valid_i = 1'b0;
      tick();
      rst = 1'b0;
      bus.irq_exec_i = 1'b0;
      checks++; if (bus.irq_ack_o !== 1'b0 || bus.redirect_valid_o !== 1'b0 || bus.trap_active_o !== 1'b0) begin
         failures++; $display("FAIL rste_state ack=%0h rv=%0h ta=%0h exp=0/0/0", bus.irq_ack_o, bus.redirect_valid_o, bus.trap_active_o);
      end
      csr_rd(12'h341, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL rste_mepc got=%08h exp=0", r); end
      csr_rd(12'h342, r);
      checks++; if (r !== 32'h0) begin failures++; $display("FAIL rste_mcause got=%08h exp=0", r); end
      csr_rd(12'h300, r);
      checks++; if (r !== 32'h0000_1800) begin failures++; $display("FAIL rste_mstatus got=%08h exp=00001800", r); end
      tick();
      checks++; if (bus.irq_ack_o !== 1'b0) begin failures++; $display("FAIL rste_late_ack got=%0h exp=0", bus.irq_ack_o); end
   endtask

   task automatic test_mret_vs_irq();
      logic [31:0] r;
      csr_wr(12'h300, 32'h0000_0080);
      csr_wr(12'h305, 32'h0000_2000);
      csr_wr(12'h341, 32'h0000_0400);
      bus.irq_exec_i  = 1'b1;
      bus.irq_cause_i = 5'd3;
      bus.mret_i      = 1'b1;
      tick();
      bus.mret_i = 1'b0;
      checks++; if (bus.redirect_valid_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_0400) begin
         failures++; $display("FAIL race_mret rv=%0h pc=%08h exp=1/00000400", bus.redirect_valid_o, bus.redirect_pc_o);
      end
      checks++; if (bus.trap_active_o !== 1'b0 || bus.mie_o !== 1'b1) begin
         failures++; $display("FAIL race_idle ta=%0h mie=%0h exp=0/1", bus.trap_active_o, bus.mie_o);
      end
      tick();
      checks++; if (bus.trap_active_o !== 1'b1 || bus.irq_ack_o !== 1'b0) begin
         failures++; $display("FAIL race_wait ta=%0h ack=%0h exp=1/0", bus.trap_active_o, bus.irq_ack_o);
      end
      bus.boundary_valid_i = 1'b1;
      bus.boundary_pc_i    = 32'h0000_0508;
      tick();
      bus.boundary_valid_i = 1'b0;
      checks++; if (bus.irq_ack_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_2000) begin
         failures++; $display("FAIL race_enter ack=%0h pc=%08h exp=1/00002000", bus.irq_ack_o, bus.redirect_pc_o);
      end
      bus.irq_exec_i = 1'b0;
      tick();
      csr_rd(12'h341, r);
      checks++; if (r !== 32'h0000_0508) begin failures++; $display("FAIL race_mepc got=%08h exp=00000508", r); end
   endtask

   task automatic test_random();
      bit          m_mie, m_mpie, m_vec, m_waiting, m_ack_due, m_ret_due, nr;
      bit          o_mie, o_mpie, prev_ack;
      logic [31:0] m_base, m_mepc, m_mcause, m_ret_pc, o_mepc;
      logic [31:0] e_pc, e_rd, wd;
      bit          e_rv, e_ta;
      logic [11:0] addrs [5];
      addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341; addrs[3] = 12'h342; addrs[4] = 12'h7C0;
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_mie = 0; m_mpie = 0; m_vec = 0; m_waiting = 0; m_ack_due = 0; m_ret_due = 0;
      m_base = '0; m_mepc = '0; m_mcause = '0; m_ret_pc = '0; prev_ack = 0;
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (bus.irq_exec_i) begin
            if (prev_ack || $urandom_range(0, 7) == 0) bus.irq_exec_i = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            bus.irq_exec_i  = 1'b1;
            bus.irq_cause_i = 5'($urandom_range(0, 31));
         end
         bus.boundary_valid_i = ($urandom_range(0, 2) == 0);
         bus.boundary_pc_i    = $urandom;
         bus.mret_i           = !m_waiting && !m_ack_due && ($urandom_range(0, 15) == 0);
         bus.csr_we_i         = ($urandom_range(0, 3) == 0);
         bus.csr_addr_i       = addrs[$urandom_range(0, 4)];
         wd = $urandom;
         if ($urandom_range(0, 7) == 0) wd = 32'hFFFF_FFF1;
         bus.csr_wdata_i = wd;
         #1;
         e_rv = m_ack_due || m_ret_due;
         e_ta = m_waiting || m_ack_due;
         e_pc = m_ret_pc;
         if (m_ack_due) e_pc = m_vec ? m_base + 32'(m_mcause[4:0]) * 32'd4 : m_base;
         case (bus.csr_addr_i)
            12'h300: e_rd = 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: e_rd = m_base | 32'(m_vec);
            12'h341: e_rd = m_mepc;
            12'h342: e_rd = m_mcause;
            default: e_rd = 32'h0;
         endcase
         checks++; if (bus.irq_ack_o !== m_ack_due) begin failures++; $display("FAIL rnd_ack n=%0d got=%0h exp=%0h", n, bus.irq_ack_o, m_ack_due); end
         checks++; if (bus.redirect_valid_o !== e_rv) begin failures++; $display("FAIL rnd_rv n=%0d got=%0h exp=%0h", n, bus.redirect_valid_o, e_rv); end
         if (e_rv) begin
            checks++; if (bus.redirect_pc_o !== e_pc) begin failures++; $display("FAIL rnd_rpc n=%0d got=%08h exp=%08h", n, bus.redirect_pc_o, e_pc); end
         end
         checks++; if (bus.trap_active_o !== e_ta) begin failures++; $display("FAIL rnd_ta n=%0d got=%0h exp=%0h", n, bus.trap_active_o, e_ta); end
         checks++; if (bus.mie_o !== m_mie) begin failures++; $display("FAIL rnd_mie n=%0d got=%0h exp=%0h", n, bus.mie_o, m_mie); end
         checks++; if (bus.csr_rdata_o !== e_rd) begin failures++; $display("FAIL rnd_rdata n=%0d addr=%03h got=%08h exp=%08h", n, bus.csr_addr_i, bus.csr_rdata_o, e_rd); end
         prev_ack = m_ack_due;
         @(posedge clk);
         if (rst) begin
            m_mie = 0; m_mpie = 0; m_vec = 0; m_waiting = 0; m_ack_due = 0; m_ret_due = 0;
            m_base = '0; m_mepc = '0; m_mcause = '0; m_ret_pc = '0; prev_ack = 0;
         end else begin
            o_mie = m_mie; o_mpie = m_mpie; o_mepc = m_mepc; nr = 0;
            if (bus.csr_we_i) begin
               case (bus.csr_addr_i)
                  12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
                  12'h305: begin m_base = {wd[31:2], 2'b00}; m_vec = (wd[1:0] == 2'b01); end
                  12'h341: m_mepc = {wd[31:2], 2'b00};
                  12'h342: m_mcause = {wd[31], 26'b0, wd[4:0]};
                  default: ;
               endcase
            end
            if (m_ack_due) begin
               m_ack_due = 0;
            end else if (m_waiting) begin
               if (!bus.irq_exec_i) m_waiting = 0;
               else if (bus.boundary_valid_i) begin
                  m_mepc    = {bus.boundary_pc_i[31:2], 2'b00};
                  m_mcause  = {1'b1, 26'b0, bus.irq_cause_i};
                  m_mpie    = o_mie;
                  m_mie     = 0;
                  m_waiting = 0;
                  m_ack_due = 1;
               end
            end else if (bus.mret_i) begin
               m_mie = o_mpie; m_mpie = 1; nr = 1; m_ret_pc = o_mepc;
            end else if (bus.irq_exec_i && o_mie) begin
               m_waiting = 1;
            end
            m_ret_due = nr;
         end
         #1;
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_trap_entry();
      test_mret();
      test_vectored();
      test_mie_gate();
      test_reset_mid();
      test_mret_vs_irq();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

endmodule
